// File: rtl/mfp_ahb_arbiter2.sv
// Two-master AHB-Lite arbiter: M0 (serial loader) and M1 (core) share one slave path.
// A master requests whenever its HTRANS is non-IDLE; the non-owner is stalled with HREADY low.
module mfp_ahb_arbiter2 #(
    parameter logic PARK_MASTER = 1'b1,
    parameter int   CNT_W       = 16
) (
    input  logic             HCLK,
    input  logic             SI_Reset,
    input  logic [31:0]      M0_HADDR,
    input  logic [1:0]       M0_HTRANS,
    input  logic             M0_HWRITE,
    input  logic [2:0]       M0_HSIZE,
    input  logic [31:0]      M0_HWDATA,
    output logic             M0_HREADY,
    output logic             M0_HRESP,
    input  logic [31:0]      M1_HADDR,
    input  logic [1:0]       M1_HTRANS,
    input  logic             M1_HWRITE,
    input  logic [2:0]       M1_HSIZE,
    input  logic [31:0]      M1_HWDATA,
    output logic             M1_HREADY,
    output logic             M1_HRESP,
    output logic [31:0]      HRDATA_M,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    output logic             ARB_OWNER,
    output logic [CNT_W-1:0] ARB_WAIT,
    input  logic             ARB_WAIT_CLR
);
    localparam logic [1:0] IDLE = 2'b00;

    logic             own;
    logic             down;
    logic             dval;
    logic [CNT_W-1:0] wait_cnt;
    logic             req0;
    logic             req1;
    logic             own_idle;
    logic             other_req;

    assign req0      = (M0_HTRANS != IDLE);
    assign req1      = (M1_HTRANS != IDLE);
    assign own_idle  = own ? !req1 : !req0;
    assign other_req = own ? req0 : req1;

    // Address phase is muxed straight through; write data follows the data-phase owner.
    assign HADDR    = own ? M1_HADDR  : M0_HADDR;
    assign HTRANS   = own ? M1_HTRANS : M0_HTRANS;
    assign HWRITE   = own ? M1_HWRITE : M0_HWRITE;
    assign HSIZE    = own ? M1_HSIZE  : M0_HSIZE;
    assign HWDATA   = down ? M1_HWDATA : M0_HWDATA;
    assign HRDATA_M = HRDATA;

    assign M0_HRESP = dval && !down && HRESP;
    assign M1_HRESP = dval &&  down && HRESP;

    assign M0_HREADY = (dval && !down) ? HREADY : (!own ? HREADY : !req0);
    assign M1_HREADY = (dval &&  down) ? HREADY : ( own ? HREADY : !req1);

    assign ARB_OWNER = own;
    assign ARB_WAIT  = wait_cnt;

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            own      <= PARK_MASTER;
            down     <= PARK_MASTER;
            dval     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (HREADY) begin
                dval <= HTRANS[1];
                down <= own;
                // Handing over only when the owner is idle keeps a master out of both phases at once.
                if (own_idle && other_req)
                    own <= !own;
            end
            if (ARB_WAIT_CLR)
                wait_cnt <= '0;
            else if (other_req && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mfp_ahb_arbiter2.sv
// Bench for mfp_ahb_arbiter2: directed table, saturation/reset sequences, then random
// traffic against a transaction-level reference model.
module tb_mfp_ahb_arbiter2;
    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] N = 2'b10;
    localparam logic [31:0] A0 = 32'hBF80_0000;
    localparam logic [31:0] A1 = 32'h1FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] hrdata_m, haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp, arb_owner, arb_clr;
    logic [2:0]  hsize;
    logic [15:0] arb_wait;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mfp_ahb_arbiter2 #(.PARK_MASTER(1'b1), .CNT_W(16)) dut (
        .HCLK(clk), .SI_Reset(rst),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
        .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
        .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
        .HRDATA_M(hrdata_m), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
        .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp),
        .ARB_OWNER(arb_owner), .ARB_WAIT(arb_wait), .ARB_WAIT_CLR(arb_clr)
    );

    typedef struct {
        logic [1:0]  t0, t1;
        logic        hr, rsp, clr;
        logic        e_own, e_rdy0, e_rdy1, e_resp0, e_resp1, e_wd;
        logic [15:0] e_wait;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] short_pack(logic own, logic r0, logic r1, logic p0, logic p1,
                                                logic [15:0] w, logic [31:0] a, logic [1:0] t,
                                                logic [31:0] wd);
        return {43'd0, a, wd, t, own, r0, r1, p0, p1, w};
    endfunction

    function automatic logic [127:0] dut_short();
        return short_pack(arb_owner, m0_hready, m1_hready, m0_hresp, m1_hresp, arb_wait,
                          haddr, htrans, hwdata);
    endfunction

    function automatic logic [127:0] dut_full();
        return {5'd0, haddr, hwdata, hrdata_m, htrans, hwrite, hsize,
                m0_hready, m1_hready, m0_hresp, m1_hresp, arb_owner, arb_wait};
    endfunction

    // Reference model state: who owns the address phase, whose transfer (if any) is in
    // the data phase, whose write data is on the bus, and the stall tally.
    int          a_own, d_own, wd_src;
    int unsigned wcnt;

    initial begin
        logic [1:0]  tr[2];
        logic [31:0] ad[2], wd[2];
        logic        wr[2];
        logic [2:0]  sz[2];
        logic        rdy[2], rsp[2];
        logic [31:0] ea;
        int          o;

        tbl[0]  = '{I, I, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[1]  = '{I, N, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[2]  = '{I, I, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[3]  = '{N, I, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[4]  = '{N, I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[5]  = '{N, N, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{I, N, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[7]  = '{I, N, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
        tbl[8]  = '{N, I, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3};
        tbl[9]  = '{N, I, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4};
        tbl[10] = '{N, I, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5};
        tbl[11] = '{N, I, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd6};
        tbl[12] = '{N, I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd7};
        tbl[13] = '{I, I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7};
        tbl[14] = '{I, I, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7};
        tbl[15] = '{I, I, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7};
        tbl[16] = '{I, I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};

        rst = 1'b1; arb_clr = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = 32'h1234_5678;
        m0_haddr = A0; m1_haddr = A1; m0_hwdata = 32'h55; m1_hwdata = 32'hAA;
        m0_htrans = I; m1_htrans = I; m0_hwrite = 1'b1; m1_hwrite = 1'b0;
        m0_hsize = 3'd2; m1_hsize = 3'd2;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: reset state, M1 read, M0 handover, back-to-back, wait states, error, clear.
        for (int r = 0; r < 17; r++) begin
            m0_htrans = tbl[r].t0; m1_htrans = tbl[r].t1; hready = tbl[r].hr;
            hresp = tbl[r].rsp; arb_clr = tbl[r].clr;
            @(negedge clk);
            ea = tbl[r].e_own ? A1 : A0;
            check($sformatf("row%0d", r), dut_short(),
                  short_pack(tbl[r].e_own, tbl[r].e_rdy0, tbl[r].e_rdy1, tbl[r].e_resp0,
                             tbl[r].e_resp1, tbl[r].e_wait, ea,
                             tbl[r].e_own ? tbl[r].t1 : tbl[r].t0,
                             tbl[r].e_wd ? 32'hAA : 32'h55));
            if (r == 2)
                check("rdata_bcast", {96'd0, hrdata_m}, {96'd0, 32'h1234_5678});
            @(posedge clk);
            #1;
        end
        arb_clr = 1'b0; hresp = 1'b0; hready = 1'b1;

        // Saturation: M0 keeps the bus with back-to-back NONSEQ while M1 waits.
        m0_htrans = N; m1_htrans = N;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("wait_full", {112'd0, arb_wait}, {112'd0, 16'hFFFF});
        check("owner_kept", {127'd0, arb_owner}, 128'd0);
        @(negedge clk);
        check("wait_sat", {112'd0, arb_wait}, {112'd0, 16'hFFFF});
        @(posedge clk); #1 arb_clr = 1'b1;
        @(posedge clk); #1 arb_clr = 1'b0;
        @(negedge clk);
        check("wait_clr", {112'd0, arb_wait}, 128'd0);

        // Reset in the middle of an M0 data phase.
        hresp = 1'b1;
        @(negedge clk);
        check("resp_pre_rst", {126'd0, m0_hresp, m1_hresp}, {126'd0, 2'b10});
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; m0_htrans = I; m1_htrans = I;
        @(negedge clk);
        check("post_rst", dut_short(), short_pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, A1, I, 32'hAA));
        hresp = 1'b0;
        @(posedge clk); #1;

        // Random traffic against the reference model.
        a_own = 1; d_own = -1; wd_src = 1; wcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                tr[m] = ($urandom_range(0, 1) != 0) ? N : I;
                ad[m] = $urandom; wd[m] = $urandom;
                wr[m] = 1'($urandom_range(0, 1)); sz[m] = 3'($urandom_range(0, 2));
            end
            m0_htrans = tr[0]; m0_haddr = ad[0]; m0_hwdata = wd[0]; m0_hwrite = wr[0]; m0_hsize = sz[0];
            m1_htrans = tr[1]; m1_haddr = ad[1]; m1_hwdata = wd[1]; m1_hwrite = wr[1]; m1_hsize = sz[1];
            hready = ($urandom_range(0, 3) != 0); hresp = ($urandom_range(0, 7) == 0);
            hrdata = $urandom; arb_clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (d_own == m || a_own == m) rdy[m] = hready;
                else rdy[m] = (tr[m] == I);
                rsp[m] = (d_own == m) && hresp;
            end
            check($sformatf("rand%0d", c), dut_full(),
                  {5'd0, ad[a_own], wd[wd_src], hrdata, tr[a_own], wr[a_own], sz[a_own],
                   rdy[0], rdy[1], rsp[0], rsp[1], 1'(a_own), 16'(wcnt)});
            if (rst) begin
                a_own = 1; d_own = -1; wd_src = 1; wcnt = 0;
            end else begin
                o = 1 - a_own;
                if (arb_clr) wcnt = 0;
                else if (tr[o] != I && wcnt < 65535) wcnt++;
                if (hready) begin
                    d_own  = (tr[a_own] != I) ? a_own : -1;
                    wd_src = a_own;
                    if (tr[a_own] == I && tr[o] != I) a_own = o;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
